// File: rtl/heu.sv
// Histogram equalization unit: equalizes one 5x80 window against its own
// 256-bin histogram and holds the result until the downstream stage takes it.
module heu (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bcau_valid,
   input  logic [4:0][79:0][7:0]  bcau_results,
   input  logic                   nnu_ready,
   output logic                   heu_ready,
   output logic                   heu_valid,
   output logic [4:0][79:0][7:0]  heu_results
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HIST = 3'd1;
   localparam logic [2:0] CDF  = 3'd2;
   localparam logic [2:0] MAP  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [8:0] LAST_PIX = 9'd399;
   localparam logic [7:0] LAST_BIN = 8'd255;

   logic [2:0]          state_q, state_d;
   logic [8:0]          pix_cnt_q, pix_cnt_d;
   logic [7:0]          bin_cnt_q, bin_cnt_d;
   logic [399:0][7:0]   pix_q;
   logic [399:0][7:0]   out_q;
   logic [255:0][8:0]   hist_q;
   logic [255:0][8:0]   cdf_q;

   logic                accept;
   logic                last_pix;
   logic                last_bin;
   logic [7:0]          cur_pix;
   logic [8:0]          cdf_sum;
   logic [16:0]         map_prod;
   logic [7:0]          map_val;

   assign heu_ready   = (state_q == IDLE);
   assign heu_valid   = (state_q == DONE);
   assign heu_results = out_q;

   assign accept   = heu_ready && bcau_valid;
   assign last_pix = (pix_cnt_q == LAST_PIX);
   assign last_bin = (bin_cnt_q == LAST_BIN);
   assign cur_pix  = pix_q[pix_cnt_q];

   // Running prefix sum; bin 0 seeds the chain from its own count.
   assign cdf_sum = (bin_cnt_q == 8'd0) ? hist_q[0]
                  : cdf_q[bin_cnt_q - 8'd1] + hist_q[bin_cnt_q];

   // cdf <= 400, so the scaled quotient never exceeds 255.
   assign map_prod = 17'(cdf_q[cur_pix]) * 17'd255;
   assign map_val  = 8'(map_prod / 17'd400);

   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      bin_cnt_d = bin_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = HIST;
               pix_cnt_d = '0;
               bin_cnt_d = '0;
            end
         end
         HIST: begin
            pix_cnt_d = pix_cnt_q + 9'd1;
            if (last_pix) begin
               state_d   = CDF;
               bin_cnt_d = '0;
            end
         end
         CDF: begin
            bin_cnt_d = bin_cnt_q + 8'd1;
            if (last_bin) begin
               state_d   = MAP;
               pix_cnt_d = '0;
            end
         end
         MAP: begin
            pix_cnt_d = pix_cnt_q + 9'd1;
            if (last_pix) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (nnu_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pix_cnt_q <= '0;
         bin_cnt_q <= '0;
         pix_q     <= '0;
         out_q     <= '0;
         hist_q    <= '0;
         cdf_q     <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         bin_cnt_q <= bin_cnt_d;
         if (accept) begin
            pix_q  <= bcau_results;
            hist_q <= '0;
         end
         if (state_q == HIST) begin
            hist_q[cur_pix] <= hist_q[cur_pix] + 9'd1;
         end
         if (state_q == CDF) begin
            cdf_q[bin_cnt_q] <= cdf_sum;
         end
         if (state_q == MAP) begin
            out_q[pix_cnt_q] <= map_val;
         end
      end
   end

endmodule

// File: tb/tb_heu.sv
// Directed bench for heu: scoreboard of reference-equalized windows,
// checked against the DUT whenever heu_valid comes up.
module tb_heu;

   typedef logic [399:0][7:0] win_t;

   logic                  clk;
   logic                  rst_n;
   logic                  bcau_valid;
   logic [4:0][79:0][7:0] bcau_results;
   logic                  nnu_ready;
   logic                  heu_ready;
   logic                  heu_valid;
   logic [4:0][79:0][7:0] heu_results;

   int   total;
   int   passed;
   win_t exp_q[$];

   heu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bcau_valid   (bcau_valid),
      .bcau_results (bcau_results),
      .nnu_ready    (nnu_ready),
      .heu_ready    (heu_ready),
      .heu_valid    (heu_valid),
      .heu_results  (heu_results)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic win_t model(input win_t w);
      int   h[256];
      int   c[256];
      int   acc;
      win_t r;
      for (int b = 0; b < 256; b++) h[b] = 0;
      for (int n = 0; n < 400; n++) h[w[n]]++;
      acc = 0;
      for (int b = 0; b < 256; b++) begin
         acc += h[b];
         c[b] = acc;
      end
      for (int n = 0; n < 400; n++) r[n] = 8'((c[w[n]] * 255) / 400);
      return r;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_win(input string tag, input win_t obs,
                          input win_t exp);
      int idx;
      idx = 0;
      for (int n = 399; n >= 0; n--) if (obs[n] !== exp[n]) idx = n;
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: pixel %0d observed %0d expected %0d",
                  tag, idx, obs[idx], exp[idx]);
   endtask

   task automatic check_out(input string tag);
      if (exp_q.size() == 0) begin
         total++;
         $error("FAIL %s: scoreboard empty, observed output unexpected", tag);
      end else begin
         chk_win(tag, heu_results, exp_q.pop_front());
      end
   endtask

   task automatic send(input win_t w);
      bcau_valid   = 1'b1;
      bcau_results = w;
      exp_q.push_back(model(w));
      @(posedge clk);
      #1;
      bcau_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!heu_valid && n < 1200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   win_t w_const, w_four, w_two, w_rand, w_next;
   int   lat;
   logic bp_valid_bad, bp_ready_bad, bp_res_bad;
   win_t held;

   initial begin
      total = 0;
      passed = 0;
      for (int n = 0; n < 400; n++) begin
         w_const[n] = 8'd100;
         w_four[n]  = 8'(n % 4);
         w_two[n]   = (n < 200) ? 8'd0 : 8'd255;
         w_rand[n]  = 8'($urandom_range(0, 255));
         w_next[n]  = 8'($urandom_range(40, 90));
      end

      rst_n = 1'b0;
      bcau_valid = 1'b0;
      nnu_ready = 1'b0;
      bcau_results = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_valid", int'(heu_valid), 0);
      chk("rst_ready", int'(heu_ready), 1);
      chk_win("rst_results", heu_results, '0);

      // constant window
      nnu_ready = 1'b1;
      send(w_const);
      chk("const_busy", int'(heu_ready), 0);
      wait_valid(lat);
      chk("const_latency", lat, 1056);
      chk("const_pix0", int'(heu_results[0][0]), 255);
      chk("const_pix399", int'(heu_results[4][79]), 255);
      check_out("const_window");
      @(posedge clk);
      #1;
      chk("const_ready_back", int'(heu_ready), 1);
      chk("const_valid_drop", int'(heu_valid), 0);

      // four-level window
      send(w_four);
      wait_valid(lat);
      chk("four_latency", lat, 1056);
      chk("four_v0", int'(heu_results[0][0]), 63);
      chk("four_v1", int'(heu_results[0][1]), 127);
      chk("four_v2", int'(heu_results[0][2]), 191);
      chk("four_v3", int'(heu_results[0][3]), 255);
      check_out("four_window");
      @(posedge clk);
      #1;

      // two-level window
      send(w_two);
      wait_valid(lat);
      chk("two_latency", lat, 1056);
      chk("two_low", int'(heu_results[2][39]), 127);
      chk("two_high", int'(heu_results[2][40]), 255);
      check_out("two_window");
      @(posedge clk);
      #1;

      // backpressure with a pending upstream window
      nnu_ready = 1'b0;
      send(w_rand);
      wait_valid(lat);
      chk("bp_latency", lat, 1056);
      check_out("bp_window");
      held = heu_results;
      bcau_valid = 1'b1;
      bcau_results = w_next;
      exp_q.push_back(model(w_next));
      bp_valid_bad = 1'b0;
      bp_ready_bad = 1'b0;
      bp_res_bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (heu_valid !== 1'b1) bp_valid_bad = 1'b1;
         if (heu_ready !== 1'b0) bp_ready_bad = 1'b1;
         if (heu_results !== held) bp_res_bad = 1'b1;
      end
      chk("bp_valid_held", int'(bp_valid_bad), 0);
      chk("bp_ready_low", int'(bp_ready_bad), 0);
      chk("bp_results_stable", int'(bp_res_bad), 0);
      nnu_ready = 1'b1;
      @(posedge clk);
      #1;
      nnu_ready = 1'b0;
      chk("bp_xfer_ready", int'(heu_ready), 1);
      chk("bp_xfer_valid", int'(heu_valid), 0);
      @(posedge clk);
      #1;
      bcau_valid = 1'b0;
      chk("bp_next_taken", int'(heu_ready), 0);
      wait_valid(lat);
      chk("bp_next_latency", lat, 1056);
      check_out("bp_next_window");
      nnu_ready = 1'b1;
      @(posedge clk);
      #1;

      // reset in the middle of HIST
      send(w_four);
      repeat (199) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      chk("mid_rst_ready", int'(heu_ready), 1);
      chk("mid_rst_valid", int'(heu_valid), 0);
      chk_win("mid_rst_results", heu_results, '0);
      send(w_four);
      wait_valid(lat);
      chk("post_rst_latency", lat, 1056);
      chk("post_rst_v0", int'(heu_results[1][0]), 63);
      chk("post_rst_v3", int'(heu_results[1][3]), 255);
      check_out("post_rst_window");
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
